// File: rtl/ysyx_25020037_lsu.sv
// Load/store unit of the ysyx_25020037 core: one EXU result per handshake, at most one AXI4-Lite beat.
// Optional misaligned-access trap is enabled by defining YSYX_25020037_LSU_MISALIGN_CHK_EN.
module ysyx_25020037_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // EXU side. Handshakes on every channel: a beat transfers on a rising clk edge where
  // valid && ready; a valid, once raised, holds its payload until the matching ready.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_rd,
  input  logic              in_gpr_we,
  output logic [DATA_W-1:0] rdata_processed,
  // AXI4-Lite read
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  // AXI4-Lite write
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  // WBU side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic              out_gpr_we,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  // FSM state for debug/checkers
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RREQ  = 3'd1,
    S_RRESP = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t state_q, state_d, dispatch;

  logic              accept;
  logic              misaligned;
  logic [2:0]        op_funct3_q;
  logic [1:0]        op_off_q;
  logic              op_gpr_we_q;
  logic              aw_done_q;
  logic              w_done_q;
  logic [3:0]        strb_calc;
  logic [DATA_W-1:0] wdata_calc;
  logic [DATA_W-1:0] rd_shift;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] load_ext;

`ifdef YSYX_25020037_LSU_MISALIGN_CHK_EN
  assign misaligned = (in_is_load || in_is_store) &&
                      ((in_funct3[1:0] == 2'b01 && in_addr[0]) ||
                       (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign accept    = in_valid && in_ready;
  assign dbg_state = state_q;

  // Load wins when both decode bits are set; trapped misaligned ops skip the bus entirely.
  always_comb begin
    dispatch = S_HOLD;
    if (!misaligned) begin
      if (in_is_load)       dispatch = S_RREQ;
      else if (in_is_store) dispatch = S_WREQ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = dispatch;
      end
      S_RREQ: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RRESP;
      end
      S_RRESP: begin
        rready = 1'b1;
        if (rvalid) state_d = S_HOLD;
      end
      S_WREQ: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if ((aw_done_q || awready) && (w_done_q || wready)) state_d = S_WRESP;
      end
      S_WRESP: begin
        bready = 1'b1;
        if (bvalid) state_d = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = in_valid ? dispatch : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (in_funct3[1:0])
      2'b00:   strb_calc = 4'b0001 << in_addr[1:0];
      2'b01:   strb_calc = 4'b0011 << in_addr[1:0];
      default: strb_calc = 4'b1111;
    endcase
    wdata_calc = in_wdata << {in_addr[1:0], 3'b000};
  end

  // Halfwords pick their lanes from offset bit 1 only, so offset 3 wraps to the upper half.
  always_comb begin
    rd_shift = rdata >> {op_off_q, 3'b000};
    rd_half  = op_off_q[1] ? rdata[31:16] : rdata[15:0];
    case (op_funct3_q)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_ext = {24'b0, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_ext = {16'b0, rd_half};
      default: load_ext = rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_funct3_q     <= '0;
      op_off_q        <= '0;
      op_gpr_we_q     <= 1'b0;
      aw_done_q       <= 1'b0;
      w_done_q        <= 1'b0;
      araddr          <= '0;
      awaddr          <= '0;
      wdata           <= '0;
      wstrb           <= '0;
      rdata_processed <= '0;
      out_rd          <= '0;
      out_gpr_we      <= 1'b0;
      out_data        <= '0;
      out_err         <= 1'b0;
    end else begin
      if (accept) begin
        op_funct3_q <= in_funct3;
        op_off_q    <= in_addr[1:0];
        op_gpr_we_q <= in_gpr_we;
        aw_done_q   <= 1'b0;
        w_done_q    <= 1'b0;
        araddr      <= {in_addr[ADDR_W-1:2], 2'b00};
        awaddr      <= {in_addr[ADDR_W-1:2], 2'b00};
        wdata       <= wdata_calc;
        wstrb       <= strb_calc;
        out_rd      <= in_rd;
        out_data    <= in_addr;
        out_err     <= misaligned;
        out_gpr_we  <= in_gpr_we && !in_is_load && !in_is_store;
      end
      if (state_q == S_WREQ) begin
        if (awvalid && awready) aw_done_q <= 1'b1;
        if (wvalid && wready)   w_done_q  <= 1'b1;
      end
      if (state_q == S_RRESP && rvalid) begin
        rdata_processed <= load_ext;
        out_data        <= load_ext;
        out_err         <= (rresp != 2'b00);
        out_gpr_we      <= op_gpr_we_q && (rresp == 2'b00);
      end
      if (state_q == S_WRESP && bvalid) begin
        out_err    <= (bresp != 2'b00);
        out_gpr_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_lsu.sv
// Bench for ysyx_25020037_lsu: random EXU traffic against a byte-level memory reference,
// with a randomly stalling AXI4-Lite slave and a scoreboard on the WBU port.
module tb_ysyx_25020037_lsu;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_is_load, in_is_store, in_gpr_we;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata, rdata_processed;
  logic [4:0]  in_rd;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;
  logic        out_valid, out_ready, out_gpr_we, out_err;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [2:0]  dbg_state;

  ysyx_25020037_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_gpr_we(in_gpr_we), .rdata_processed(rdata_processed),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_gpr_we(out_gpr_we), .out_data(out_data), .out_err(out_err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  // exp entry: {is_load, err, gpr_we, rd[4:0], data[31:0]}
  logic [39:0] exp_q[$];
  // bus entry: {is_write, err, addr[31:0], strb[3:0], data[31:0]}
  logic [69:0] bus_q[$];
  logic [31:0] mem[64];
  logic [31:0] ref_mem[64];
  bit ordy_force = 1'b0;
  bit r_stall    = 1'b0;
  bit err_en     = 1'b1;
  bit err_force  = 1'b0;
  int ov_run = 0;
  int ov_max = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    int lo;
    b  = word[8*int'(a) +: 8];
    lo = a[1] ? 16 : 0;
    h  = word[lo +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return word;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] wd,
                           output logic [3:0] sb, output logic [31:0] sd);
    int n;
    int ai;
    ai = int'(a);
    n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    sb = '0;
    sd = '0;
    for (int lane = 0; lane < 4; lane++) begin
      sb[lane] = (n == 4) || (lane >= ai && lane < ai + n);
      if (lane >= ai) sd[8*lane +: 8] = wd[8*(lane-ai) +: 8];
    end
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic we);
    logic err;
    logic [3:0]  sb;
    logic [31:0] sd;
    int idx;
    bit ok;
    idx = int'(addr[7:2]);
    err = err_force || (err_en && $urandom_range(0, 7) == 0);
    if (ld) begin
      exp_q.push_back({1'b1, err, we & ~err, rd, ref_load(ref_mem[idx], f3, addr[1:0])});
      bus_q.push_back({1'b0, err, addr & 32'hFFFF_FFFC, 4'b0, 32'b0});
    end else if (st) begin
      ref_store(f3, addr[1:0], wd, sb, sd);
      if (!err)
        for (int l = 0; l < 4; l++)
          if (sb[l]) ref_mem[idx][8*l +: 8] = sd[8*l +: 8];
      exp_q.push_back({1'b0, err, 1'b0, rd, addr});
      bus_q.push_back({1'b1, err, addr & 32'hFFFF_FFFC, sb, sd});
    end else begin
      exp_q.push_back({1'b0, 1'b0, we, rd, addr});
    end
    in_is_load = ld; in_is_store = st; in_funct3 = f3; in_addr = addr;
    in_wdata = wd; in_rd = rd; in_gpr_we = we; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready never 1, required 1");
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------- WBU ready ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = ordy_force ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        ov_run++;
        if (ov_run > ov_max) ov_max = ov_run;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out: out_data %h with no expected result", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[31:0]);
          check("out_rd", 32'(out_rd), 32'(e[36:32]));
          check("out_gpr_we", 32'(out_gpr_we), 32'(e[37]));
          check("out_err", 32'(out_err), 32'(e[38]));
          if (e[39]) check("rdata_processed", rdata_processed, e[31:0]);
        end
      end else begin
        ov_run = 0;
      end
    end
  end

  // ---------------- AXI4-Lite slave ----------------
  initial begin
    bit ar_f, r_f, aw_f, w_f, b_f, bready_prev;
    bit r_pend, r_err, aw_got, w_got, b_issued, b_err;
    int r_idx;
    logic [31:0] s_araddr, s_awaddr, s_wdata, c_awaddr, c_wdata;
    logic [3:0]  s_wstrb, c_wstrb;
    logic [69:0] be;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    r_pend = 0; r_err = 0; aw_got = 0; w_got = 0; b_issued = 0; b_err = 0; r_idx = 0;
    bready_prev = 0; c_awaddr = 0; c_wdata = 0; c_wstrb = 0;
    forever begin
      @(negedge clk);
      ar_f = arvalid && arready; r_f = rvalid && rready;
      aw_f = awvalid && awready; w_f = wvalid && wready; b_f = bvalid && bready;
      s_araddr = araddr; s_awaddr = awaddr; s_wdata = wdata; s_wstrb = wstrb;
      if (bready && !bready_prev) check("bready_after_aw_and_w", 32'(aw_got && w_got), 32'd1);
      bready_prev = bready;
      @(posedge clk); #1;
      if (!rst) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        r_pend = 0; aw_got = 0; w_got = 0; b_issued = 0; bready_prev = 0;
        continue;
      end
      if (ar_f) begin
        arready = 1'b0;
        if (bus_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ar: araddr %h with no expected transaction", s_araddr);
        end else begin
          be = bus_q.pop_front();
          check("ar_kind_read", 32'(be[69]), 32'd0);
          check("araddr", s_araddr, be[67:36]);
          r_err = be[68];
        end
        r_pend = 1'b1;
        r_idx  = int'(s_araddr[7:2]);
      end else begin
        arready = arvalid && !r_pend && ($urandom_range(0, 2) == 0);
      end
      if (r_f) begin
        rvalid = 1'b0; r_pend = 1'b0;
      end else if (r_pend && !rvalid && !r_stall && $urandom_range(0, 1) == 1) begin
        rvalid = 1'b1; rdata = mem[r_idx]; rresp = r_err ? 2'b10 : 2'b00;
      end
      if (aw_f) begin
        awready = 1'b0; aw_got = 1'b1; c_awaddr = s_awaddr;
      end else begin
        awready = awvalid && !aw_got && ($urandom_range(0, 2) == 0);
      end
      if (w_f) begin
        wready = 1'b0; w_got = 1'b1; c_wdata = s_wdata; c_wstrb = s_wstrb;
      end else begin
        wready = wvalid && !w_got && ($urandom_range(0, 3) == 0);
      end
      if (b_f) begin
        bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_issued = 1'b0;
      end else if (aw_got && w_got && !b_issued) begin
        b_issued = 1'b1;
        b_err    = 1'b0;
        if (bus_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_aw: awaddr %h with no expected transaction", c_awaddr);
        end else begin
          be = bus_q.pop_front();
          check("aw_kind_write", 32'(be[69]), 32'd1);
          check("awaddr", c_awaddr, be[67:36]);
          check("wstrb", 32'(c_wstrb), 32'(be[35:32]));
          check("wdata", c_wdata, be[31:0]);
          b_err = be[68];
        end
        if (!b_err)
          for (int l = 0; l < 4; l++)
            if (c_wstrb[l]) mem[c_awaddr[7:2]][8*l +: 8] = c_wdata[8*l +: 8];
      end else if (b_issued && !bvalid && $urandom_range(0, 1) == 1) begin
        bvalid = 1'b1; bresp = b_err ? 2'b10 : 2'b00;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [2:0] f3_tab[5];
  initial begin
    int c0, kind;
    logic [31:0] a;
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
    in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = 0;
    in_addr = 0; in_wdata = 0; in_rd = 0; in_gpr_we = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_valids", 32'({arvalid, rready, awvalid, wvalid, bready, out_valid}), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_rdata_processed", rdata_processed, 32'd0);
    check("reset_bus_payload", araddr | awaddr | wdata | 32'(wstrb), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // sign-extended byte at offset 3, then a halfword store at offset 2
    err_en = 1'b0;
    mem[0] = 32'h80FF_1234; ref_mem[0] = 32'h80FF_1234;
    issue(1, 0, 3'b000, 32'h8000_0003, 32'h0, 5'd3, 1'b1);
    issue(0, 1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 5'd4, 1'b1);
    issue(1, 0, 3'b010, 32'h8000_0000, 32'h0, 5'd5, 1'b1);
    issue(1, 0, 3'b101, 32'h8000_0003, 32'h0, 5'd6, 1'b1);
    drain(500);

    // read error keeps the result flowing but kills the writeback
    err_force = 1'b1;
    issue(1, 0, 3'b010, 32'h8000_0010, 32'h0, 5'd7, 1'b1);
    issue(0, 1, 3'b010, 32'h8000_0014, 32'h1234_5678, 5'd8, 1'b0);
    err_force = 1'b0;
    drain(500);

    // three ALU results back to back
    ordy_force = 1'b1;
    drain(50);
    @(posedge clk); #1;
    ov_max = 0;
    c0 = cyc;
    issue(0, 0, 3'b000, 32'h1111_0001, 32'h0, 5'd1, 1'b1);
    issue(0, 0, 3'b000, 32'h2222_0002, 32'h0, 5'd2, 1'b1);
    issue(0, 0, 3'b000, 32'h3333_0003, 32'h0, 5'd3, 1'b0);
    check("b2b_accept_cycles", 32'(cyc - c0), 32'd3);
    drain(50);
    check("b2b_out_valid_run", 32'(ov_max >= 3), 32'd1);
    ordy_force = 1'b0;

    // reset while the load waits for read data
    r_stall = 1'b1;
    issue(1, 0, 3'b010, 32'h8000_0020, 32'h0, 5'd9, 1'b1);
    c0 = 0;
    while (!rready && c0 < 100) begin
      @(negedge clk); c0++;
    end
    check("rresp_reached", 32'(rready), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midreset_valids", 32'({arvalid, rready, awvalid, wvalid, bready, out_valid}), 32'd0);
    @(posedge clk); #1;
    check("midreset_idle_in_ready", 32'(in_ready), 32'd1);
    check("midreset_valids_next", 32'({arvalid, rready, awvalid, wvalid, bready, out_valid}), 32'd0);
    exp_q.delete();
    bus_q.delete();
    r_stall = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(0, 0, 3'b000, 32'hCAFE_F00D, 32'h0, 5'd10, 1'b1);
    drain(100);

    // randomized mix
    err_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 19);
      a = 32'h8000_0000 | 32'($urandom_range(0, 255));
      if (kind < 7)
        issue(0, 0, 3'b000, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else if (kind < 13)
        issue(1, 0, f3_tab[$urandom_range(0, 4)], a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else if (kind < 19)
        issue(0, 1, f3_tab[$urandom_range(0, 2)], a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else
        issue(1, 1, f3_tab[$urandom_range(0, 4)], a, $urandom, 5'($urandom_range(0, 31)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain(3000);
    check("bus_queue_empty", 32'(bus_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
